// File: rtl/alloc_free_list_if.sv
// Free-list bundle: allocation, release, checkpoint and flush signals.
// The master drives requests; the slave (the free list) drives grants and status.
interface alloc_free_list_if #(
  parameter int NUM_PREG   = 64,
  parameter int ALLOC_W    = 4,
  parameter int REL_W      = 4,
  parameter int CKPT_DEPTH = 4
);
  localparam int PREG_W = $clog2(NUM_PREG);
  localparam int CKPT_W = $clog2(CKPT_DEPTH);

  logic                      stall;
  logic [ALLOC_W-1:0]        alloc_req;
  logic [ALLOC_W-1:0]        alloc_gnt;
  logic [ALLOC_W*PREG_W-1:0] alloc_preg;
  logic                      list_empty;
  logic [PREG_W:0]           free_cnt;
  logic [REL_W-1:0]          rel_vld;
  logic [REL_W*PREG_W-1:0]   rel_preg;
  logic                      ckpt_req;
  logic [CKPT_W-1:0]         ckpt_id;
  logic                      ckpt_full;
  logic                      ckpt_cmt;
  logic                      flush;
  logic [CKPT_W-1:0]         flush_id;

  modport master (
    output stall, alloc_req, rel_vld, rel_preg, ckpt_req, ckpt_cmt, flush, flush_id,
    input  alloc_gnt, alloc_preg, list_empty, free_cnt, ckpt_id, ckpt_full
  );

  modport slave (
    input  stall, alloc_req, rel_vld, rel_preg, ckpt_req, ckpt_cmt, flush, flush_id,
    output alloc_gnt, alloc_preg, list_empty, free_cnt, ckpt_id, ckpt_full
  );
endinterface

// File: rtl/alloc_free_list.sv
// Physical-register free list with multi-slot allocation, multi-port release and
// checkpoint/flush recovery. Define FL_PARTIAL_ALLOC_EN for partial grants.
module alloc_free_list #(
  parameter int NUM_PREG   = 64,
  parameter int NUM_ARCH   = 16,
  parameter int ALLOC_W    = 4,
  parameter int REL_W      = 4,
  parameter int CKPT_DEPTH = 4
) (
  input logic              clk_i,
  input logic              rst_i,
  alloc_free_list_if.slave fl
);
  localparam int PREG_W = $clog2(NUM_PREG);
  localparam int CKPT_W = $clog2(CKPT_DEPTH);
  typedef logic [PREG_W:0] ptr_t;

  logic [PREG_W-1:0]         mem_q [NUM_PREG];
  ptr_t                      head_q, head_d, tail_q, tail_d, free_cnt_q;
  ptr_t                      ckpt_head_q [CKPT_DEPTH];
  logic [CKPT_W-1:0]         ckpt_hd_q, ckpt_hd_d, ckpt_tl_q, ckpt_tl_d;
  logic [CKPT_W:0]           ckpt_cnt_q, ckpt_cnt_d;
  logic [ALLOC_W-1:0]        gnt;
  logic [ALLOC_W*PREG_W-1:0] preg_bus;
  ptr_t                      n_req, n_gnt, n_rel;
  logic [PREG_W-1:0]         rel_addr [REL_W];
  logic                      alloc_go, ckpt_push, ckpt_full;

  assign ckpt_full = (ckpt_cnt_q == (CKPT_W+1)'(CKPT_DEPTH));
  assign alloc_go  = ~fl.stall & ~fl.flush;
  assign ckpt_push = fl.ckpt_req & alloc_go & ~ckpt_full;

  always_comb begin
    n_req    = '0;
    n_gnt    = '0;
    gnt      = '0;
    preg_bus = '0;
    for (int i = 0; i < ALLOC_W; i++) n_req = n_req + ptr_t'(fl.alloc_req[i]);
    for (int i = 0; i < ALLOC_W; i++) begin
`ifdef FL_PARTIAL_ALLOC_EN
      if (fl.alloc_req[i] && (n_gnt < free_cnt_q)) begin
`else
      if (fl.alloc_req[i] && (n_req <= free_cnt_q)) begin
`endif
        gnt[i] = 1'b1;
        preg_bus[i*PREG_W +: PREG_W] = mem_q[head_q[PREG_W-1:0] + n_gnt[PREG_W-1:0]];
        n_gnt = n_gnt + ptr_t'(1);
      end
    end
  end

  always_comb begin
    n_rel = '0;
    for (int j = 0; j < REL_W; j++) begin
      rel_addr[j] = tail_q[PREG_W-1:0] + n_rel[PREG_W-1:0];
      n_rel       = n_rel + ptr_t'(fl.rel_vld[j]);
    end
  end

  always_comb begin
    tail_d    = tail_q + n_rel;
    head_d    = head_q + (alloc_go ? n_gnt : '0);
    ckpt_hd_d = ckpt_hd_q + CKPT_W'(fl.ckpt_cmt);
    ckpt_tl_d = ckpt_tl_q + CKPT_W'(ckpt_push);
    ckpt_cnt_d = ckpt_cnt_q + (CKPT_W+1)'(ckpt_push) - (CKPT_W+1)'(fl.ckpt_cmt);
    if (fl.flush) begin
      // Live checkpoints after a flush are those strictly older than flush_id.
      head_d     = ckpt_head_q[fl.flush_id];
      ckpt_tl_d  = fl.flush_id;
      ckpt_cnt_d = {1'b0, fl.flush_id - ckpt_hd_d};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_PREG; i++)
        mem_q[i] <= (i < NUM_PREG - NUM_ARCH) ? PREG_W'(NUM_ARCH + i) : '0;
      for (int c = 0; c < CKPT_DEPTH; c++) ckpt_head_q[c] <= '0;
      head_q     <= '0;
      tail_q     <= ptr_t'(NUM_PREG - NUM_ARCH);
      free_cnt_q <= ptr_t'(NUM_PREG - NUM_ARCH);
      ckpt_hd_q  <= '0;
      ckpt_tl_q  <= '0;
      ckpt_cnt_q <= '0;
    end else begin
      for (int j = 0; j < REL_W; j++)
        if (fl.rel_vld[j]) mem_q[rel_addr[j]] <= fl.rel_preg[j*PREG_W +: PREG_W];
      // head_d here is the post-allocation head, since a push excludes flush.
      if (ckpt_push) ckpt_head_q[ckpt_tl_q] <= head_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      free_cnt_q <= tail_d - head_d;
      ckpt_hd_q  <= ckpt_hd_d;
      ckpt_tl_q  <= ckpt_tl_d;
      ckpt_cnt_q <= ckpt_cnt_d;
    end
  end

  assign fl.alloc_gnt  = gnt;
  assign fl.alloc_preg = preg_bus;
  assign fl.free_cnt   = free_cnt_q;
  assign fl.list_empty = (free_cnt_q < ptr_t'(ALLOC_W));
  assign fl.ckpt_id    = ckpt_tl_q;
  assign fl.ckpt_full  = ckpt_full;
endmodule

// File: tb/tb_alloc_free_list.sv
// Directed bench for alloc_free_list at default parameters; expectations are
// hand-computed and follow FL_PARTIAL_ALLOC_EN when it is defined.
module tb_alloc_free_list;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  alloc_free_list_if #(.NUM_PREG(64), .ALLOC_W(4), .REL_W(4), .CKPT_DEPTH(4)) fl_if ();

  alloc_free_list #(
    .NUM_PREG(64), .NUM_ARCH(16), .ALLOC_W(4), .REL_W(4), .CKPT_DEPTH(4)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .fl    (fl_if)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    fl_if.stall     = 1'b0;
    fl_if.alloc_req = '0;
    fl_if.rel_vld   = '0;
    fl_if.rel_preg  = '0;
    fl_if.ckpt_req  = 1'b0;
    fl_if.ckpt_cmt  = 1'b0;
    fl_if.flush     = 1'b0;
    fl_if.flush_id  = '0;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    idle();
    tick();
    do_reset();

    // Reset state
    chk("rst_free_cnt", fl_if.free_cnt, 48);
    chk("rst_empty", fl_if.list_empty, 0);
    chk("rst_ckpt_id", fl_if.ckpt_id, 0);
    chk("rst_ckpt_full", fl_if.ckpt_full, 0);

    // Full-width allocation
    fl_if.alloc_req = 4'b1111;
    settle();
    chk("a4_gnt", fl_if.alloc_gnt, 4'b1111);
    chk("a4_preg", fl_if.alloc_preg, {6'd19, 6'd18, 6'd17, 6'd16});
    tick();
    idle();
    chk("a4_free", fl_if.free_cnt, 44);

    // Sparse request mask
    do_reset();
    fl_if.alloc_req = 4'b1010;
    settle();
    chk("sparse_gnt", fl_if.alloc_gnt, 4'b1010);
    chk("sparse_preg", fl_if.alloc_preg, {6'd17, 6'd0, 6'd16, 6'd0});
    tick();
    idle();
    chk("sparse_free", fl_if.free_cnt, 46);

    // Stall holds the head
    do_reset();
    fl_if.stall     = 1'b1;
    fl_if.alloc_req = 4'b1111;
    tick();
    idle();
    chk("stall_free", fl_if.free_cnt, 48);

    // Drain, release three, then a 4-wide request against 3 free
    for (int c = 0; c < 12; c++) begin
      fl_if.alloc_req = 4'b1111;
      tick();
    end
    idle();
    chk("drain_free", fl_if.free_cnt, 0);
    chk("drain_empty", fl_if.list_empty, 1);
    fl_if.rel_vld  = 4'b0111;
    fl_if.rel_preg = {6'd0, 6'd7, 6'd6, 6'd5};
    settle();
    chk("no_bypass_gnt", fl_if.alloc_gnt, 0);
    tick();
    idle();
    chk("rel_free", fl_if.free_cnt, 3);
    chk("rel_empty", fl_if.list_empty, 1);
    fl_if.alloc_req = 4'b1111;
    settle();
`ifdef FL_PARTIAL_ALLOC_EN
    chk("part_gnt", fl_if.alloc_gnt, 4'b0111);
    chk("part_preg", fl_if.alloc_preg, {6'd0, 6'd7, 6'd6, 6'd5});
    tick();
    idle();
    chk("part_free", fl_if.free_cnt, 0);
`else
    chk("aon_gnt", fl_if.alloc_gnt, 0);
    chk("aon_preg", fl_if.alloc_preg, 0);
    tick();
    idle();
    chk("aon_free", fl_if.free_cnt, 3);
`endif

    // Checkpoint then flush restores head
    do_reset();
    fl_if.alloc_req = 4'b1111;
    fl_if.ckpt_req  = 1'b1;
    settle();
    chk("ck_id0", fl_if.ckpt_id, 0);
    tick();
    idle();
    chk("ck_id_after", fl_if.ckpt_id, 1);
    fl_if.alloc_req = 4'b1111;
    tick();
    tick();
    idle();
    chk("ck_free36", fl_if.free_cnt, 36);
    fl_if.flush    = 1'b1;
    fl_if.flush_id = 2'd0;
    tick();
    idle();
    chk("fl_free44", fl_if.free_cnt, 44);
    chk("fl_ckpt_id", fl_if.ckpt_id, 0);
    fl_if.alloc_req = 4'b0001;
    settle();
    chk("fl_next_preg", fl_if.alloc_preg, 20);
    tick();
    idle();

    // Flush, release and allocation in one cycle
    do_reset();
    fl_if.alloc_req = 4'b1111;
    fl_if.ckpt_req  = 1'b1;
    tick();
    idle();
    fl_if.alloc_req = 4'b1111;
    tick();
    idle();
    chk("mix_pre_free", fl_if.free_cnt, 40);
    fl_if.flush     = 1'b1;
    fl_if.flush_id  = 2'd0;
    fl_if.alloc_req = 4'b1111;
    fl_if.rel_vld   = 4'b0011;
    fl_if.rel_preg  = {6'd0, 6'd0, 6'd2, 6'd1};
    tick();
    idle();
    chk("mix_free", fl_if.free_cnt, 46);
    fl_if.alloc_req = 4'b0001;
    settle();
    chk("mix_next_preg", fl_if.alloc_preg, 20);

    // Checkpoint FIFO fill, overflow drop, commit
    do_reset();
    for (int c = 0; c < 4; c++) begin
      fl_if.ckpt_req = 1'b1;
      tick();
    end
    idle();
    chk("full_set", fl_if.ckpt_full, 1);
    chk("full_id", fl_if.ckpt_id, 0);
    fl_if.ckpt_req = 1'b1;
    tick();
    idle();
    chk("drop_id", fl_if.ckpt_id, 0);
    chk("drop_full", fl_if.ckpt_full, 1);
    fl_if.ckpt_cmt = 1'b1;
    tick();
    idle();
    chk("cmt_full", fl_if.ckpt_full, 0);
    fl_if.ckpt_req = 1'b1;
    tick();
    idle();
    chk("cmt_push_id", fl_if.ckpt_id, 1);
    chk("cmt_refull", fl_if.ckpt_full, 1);

    // Mid-run reset clears checkpoints and pointers
    fl_if.alloc_req = 4'b1111;
    tick();
    idle();
    do_reset();
    chk("rerst_free", fl_if.free_cnt, 48);
    chk("rerst_full", fl_if.ckpt_full, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1);
  end
endmodule
